// File: rtl/hazard_if.sv
// Hazard-unit bus: pipeline-stage register addresses and control bits in,
// forward selects, stall/clear controls, busy flag and event counters out.
//   master : pipeline side (drives stage info, receives hazard controls)
//   slave  : hazard unit side
interface hazard_if #(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned CNT_W  = 16
);
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic              id_alusrc;
   logic [REG_AW-1:0] mem_rd;
   logic [REG_AW-1:0] wr_rd;
   logic              mem_regwr;
   logic              wr_regwr;
   logic [REG_AW-1:0] ex_rd;
   logic              ex_load;
   logic              ex_regwr;
   logic              jump;
   logic              branch_taken;

   logic [1:0]        alusrc_a;
   logic [1:0]        alusrc_b;
   logic              pc_stall;
   logic              if_id_stall;
   logic              if_id_clr;
   logic              id_ex_clr;
   logic              ex_mem_clr;
   logic              busy;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;

   modport master (
      output id_rs, id_rt, id_alusrc, mem_rd, wr_rd, mem_regwr, wr_regwr,
             ex_rd, ex_load, ex_regwr, jump, branch_taken,
      input  alusrc_a, alusrc_b, pc_stall, if_id_stall, if_id_clr,
             id_ex_clr, ex_mem_clr, busy, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_rs, id_rt, id_alusrc, mem_rd, wr_rd, mem_regwr, wr_regwr,
             ex_rd, ex_load, ex_regwr, jump, branch_taken,
      output alusrc_a, alusrc_b, pc_stall, if_id_stall, if_id_clr,
             id_ex_clr, ex_mem_clr, busy, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use stalls and multi-cycle
// branch/jump flushes, with saturating stall/flush event counters.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : hazard_if slave modport (stage info in, controls out)
// Forward selects and stall/clear controls are combinational (they must act
// in the cycle the event is seen); state and counters are registered.
module hazard_unit #(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned BR_PEN = 1,
   parameter int unsigned J_PEN  = 1,
   parameter int unsigned CNT_W  = 16
) (
   input logic     clk,
   input logic     rst_n,
   hazard_if.slave bus
);
   localparam int unsigned FCNT_W = 3;
   localparam logic [0:0] RUN   = 1'b0;
   localparam logic [0:0] FLUSH = 1'b1;
   localparam logic [FCNT_W-1:0] BR_RELOAD = FCNT_W'(BR_PEN - 1);
   localparam logic [FCNT_W-1:0] J_RELOAD  = FCNT_W'(J_PEN - 1);
   localparam logic [REG_AW-1:0] ZERO_REG  = '0;
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   logic [0:0]        state_q, state_d;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;
   logic              br_mode_q, br_mode_d;
   logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;

   logic load_use_c;
   logic stall_c, if_id_clr_c, id_ex_clr_c, ex_mem_clr_c;
   logic any_clr_c;

   // Mem > Wr > register file; register 0 never forwards.
   function automatic logic [1:0] fwd_sel(
      input logic [REG_AW-1:0] src,
      input logic [REG_AW-1:0] m_rd,
      input logic              m_we,
      input logic [REG_AW-1:0] w_rd,
      input logic              w_we
   );
      logic [1:0] sel;
      sel = 2'd0;
      if (m_we && (m_rd != ZERO_REG) && (m_rd == src))
         sel = 2'd1;
      else if (w_we && (w_rd != ZERO_REG) && (w_rd == src))
         sel = 2'd2;
      return sel;
   endfunction

   // Forward selects: independent of reset and FSM state.
   always_comb begin
      bus.alusrc_a = fwd_sel(bus.id_rs, bus.mem_rd, bus.mem_regwr,
                             bus.wr_rd, bus.wr_regwr);
      bus.alusrc_b = bus.id_alusrc ? 2'd3 :
                     fwd_sel(bus.id_rt, bus.mem_rd, bus.mem_regwr,
                             bus.wr_rd, bus.wr_regwr);
   end

   // Load-use: operand B only matters when it comes from the register file.
   assign load_use_c = bus.ex_load && bus.ex_regwr && (bus.ex_rd != ZERO_REG) &&
                       ((bus.ex_rd == bus.id_rs) ||
                        ((bus.ex_rd == bus.id_rt) && !bus.id_alusrc));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= RUN;
         fcnt_q    <= '0;
         br_mode_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         fcnt_q    <= fcnt_d;
         br_mode_q <= br_mode_d;
      end
   end

   // Next-state and control decode.
   always_comb begin
      state_d      = state_q;
      fcnt_d       = fcnt_q;
      br_mode_d    = br_mode_q;
      stall_c      = 1'b0;
      if_id_clr_c  = 1'b0;
      id_ex_clr_c  = 1'b0;
      ex_mem_clr_c = 1'b0;
      case (state_q)
         RUN: begin
            if (bus.branch_taken) begin
               if_id_clr_c  = 1'b1;
               id_ex_clr_c  = 1'b1;
               ex_mem_clr_c = 1'b1;
               if (BR_PEN > 1) begin
                  state_d   = FLUSH;
                  fcnt_d    = BR_RELOAD;
                  br_mode_d = 1'b1;
               end
            end else if (bus.jump) begin
               if_id_clr_c = 1'b1;
               id_ex_clr_c = 1'b1;
               if (J_PEN > 1) begin
                  state_d   = FLUSH;
                  fcnt_d    = J_RELOAD;
                  br_mode_d = 1'b0;
               end
            end else if (load_use_c) begin
               stall_c     = 1'b1;
               id_ex_clr_c = 1'b1;
            end
         end
         FLUSH: begin
            if_id_clr_c = 1'b1;
            id_ex_clr_c = 1'b1;
            if (bus.branch_taken) begin
               // A new branch restarts the flush window in branch mode.
               ex_mem_clr_c = 1'b1;
               fcnt_d       = BR_RELOAD;
               br_mode_d    = 1'b1;
               if (BR_PEN == 1)
                  state_d = RUN;
            end else begin
               ex_mem_clr_c = br_mode_q;
               fcnt_d       = fcnt_q - FCNT_W'(1);
               if (fcnt_q == FCNT_W'(1))
                  state_d = RUN;
            end
         end
         default: begin
            state_d = RUN;
            fcnt_d  = '0;
         end
      endcase
   end

   assign any_clr_c = if_id_clr_c || id_ex_clr_c || ex_mem_clr_c;

   // Controls are forced low while reset is held.
   always_comb begin
      bus.pc_stall    = rst_n && stall_c;
      bus.if_id_stall = rst_n && stall_c;
      bus.if_id_clr   = rst_n && if_id_clr_c;
      bus.id_ex_clr   = rst_n && id_ex_clr_c;
      bus.ex_mem_clr  = rst_n && ex_mem_clr_c;
      bus.busy        = (state_q == FLUSH);
      bus.stall_cnt   = stall_cnt_q;
      bus.flush_cnt   = flush_cnt_q;
   end

   // Saturating event counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall_c && (stall_cnt_q != CNT_MAX))
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (any_clr_c && (flush_cnt_q != CNT_MAX))
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end
endmodule
